hazard_ctl: RTL and testbench
=============================

# hazard_ctl

Pipeline sequencing controller for the five-stage MIPS core. Watches the IF/ID and ID/EX pipeline registers, the EX/MEM branch outcome and the data-memory busy handshake. Drives the PC and pipeline-register write enables, bubbles and flushes around the decode stage. Provides load-use stalls, taken-branch flushes and whole-pipeline freeze from one state machine.

## Interface
Parameters:
- STALL_CYCLES, 1: load-use stall length in cycles.
  - Legal range 1..3.
  - Use 2 or 3 when EX forwarding is absent.

Ports:
- clk  in  1: pipeline clock, rising edge.
- rst  in  1: synchronous, active-high reset.
- IF_ID_rs  in  5: instruction[25:21] of the instruction in decode.
- IF_ID_rt  in  5: instruction[20:16] of the instruction in decode.
- ID_EX_mem_read  in  1: M-control mem_read bit of the instruction in EX.
- ID_EX_rt  in  5: destination rt of the instruction in EX.
- EX_MEM_branch_taken  in  1: branch resolved taken (pcsrc).
- dmem_busy  in  1: data memory not ready; the pipeline must hold.
- pc_write  out  1: PC load enable.
- if_id_write  out  1: IF/ID load enable.
- if_id_flush  out  1: IF/ID loads a NOP.
- id_ex_bubble  out  1: zero the WB/M/EX control fields into ID/EX.
- id_ex_flush  out  1: ID/EX loads all-zero.
- ex_mem_flush  out  1: EX/MEM control fields load zero.
- pipe_freeze  out  1: all pipeline registers hold; overrides every other output.
- ctl_state  out  2: current state, for debug.
- stall_count  out  32: performance counter.
- flush_count  out  32: performance counter.
- freeze_count  out  32: performance counter.

## Operation
States: RUN=00, STALL=01, FLUSH=10.

Load-use hazard, hz, is true when all of these hold:
- ID_EX_mem_read = 1
- ID_EX_rt ≠ 0
- ID_EX_rt equals IF_ID_rs or IF_ID_rt

Output priority, per cycle: freeze > flush > stall > run.
- **Freeze** (dmem_busy=1):
  - pipe_freeze=1; pc_write=0; if_id_write=0.
  - All flush and bubble outputs are 0.
  - State and stall counter hold.
  - A pending branch flush is not lost: EX/MEM is frozen, so branch_taken stays asserted and the flush fires on the first unfrozen cycle.
- **Flush** (EX_MEM_branch_taken=1, not frozen):
  - if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, pc_write=1, if_id_write=1.
  - The stall counter clears. Next state is FLUSH for exactly one cycle, then RUN.
  - A branch flush cancels an in-progress load-use stall.
- **Stall entry** (in RUN, hz=1, no flush, no freeze):
  - pc_write=0, if_id_write=0, id_ex_bubble=1.
  - The counter loads STALL_CYCLES-1. Next state is STALL if STALL_CYCLES>1, otherwise RUN.
- **STALL state**:
  - Same outputs as stall entry.
  - The counter decrements each unfrozen cycle. At count 0 the next state is RUN.
  - hz is not re-evaluated while in STALL.
- **RUN with no event**: pc_write=1, if_id_write=1, all others 0.
- **FLUSH state, no new event**: behaves as RUN, then moves to RUN. A new branch_taken or hz in this cycle is handled as it would be in RUN.

## Timing
- Hazard and control outputs are combinational from the current state and inputs in the same cycle. State and counters update on the rising clk edge.
- Reset, effective on the edge with rst=1:
  - State is RUN and the counter is 0.
  - All performance counters are 0.
- While rst=1, outputs read as: pc_write=1, if_id_write=1, all other outputs 0.
- Stall timing:
  - A load-use pair produces exactly STALL_CYCLES cycles with pc_write=0, starting in the cycle hz is first seen.
  - The dependent instruction leaves ID on the next edge after the stall ends.
- Freeze cycles stretch any state by exactly their count; the stall length excludes frozen cycles.
- Reset asserted mid-STALL returns to RUN on that edge. No stall cycles remain.
- Counter arithmetic: 32-bit unsigned, wraps from 0xFFFFFFFF to 0.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_count increments once per cycle with id_ex_bubble=1.
  - flush_count increments once per cycle with id_ex_flush=1.
  - freeze_count increments once per cycle with pipe_freeze=1.
- HAZARD_PERF_EN undefined:
  - The counters are not built.
  - stall_count, flush_count and freeze_count are tied to 0.
  - Control behaviour is identical.

## Test plan
- **Single stall**: STALL_CYCLES=1, lw $t1 in EX with ID_EX_rt=9, mem_read=1, IF_ID_rs=9.
  - Expect 1 cycle of pc_write=0, id_ex_bubble=1, then RUN.
  - stall_count=1.
- **Multi-cycle stall**: STALL_CYCLES=3, same pair.
  - Expect 3 consecutive stall cycles and ctl_state 01 for 2 of them, then RUN.
- **rt=$zero**: ID_EX_rt=0 with mem_read=1 and IF_ID_rs=0.
  - Expect no stall; pc_write stays 1.
- **Branch during stall**: branch_taken=1 in the 2nd cycle of a 3-cycle stall.
  - Expect all three flush outputs=1, pc_write=1, FLUSH for 1 cycle, then RUN with no further stall cycles.
- **Freeze over flush**: dmem_busy=1 for 4 cycles while branch_taken=1.
  - Expect pipe_freeze=1 and zero flush outputs for 4 cycles, then the flush fires on cycle 5.
  - freeze_count=4, flush_count=1.
- **Reset mid-stall**: rst=1 in cycle 1 of a 3-cycle stall.
  - Expect ctl_state=00 next cycle, pc_write=1, all counters 0.

Source files
------------

// File: rtl/hazard_ctl.sv
// Decode-stage sequencer: load-use stall, branch flush and memory freeze.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctl #(
  parameter int STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic        ID_EX_mem_read,
  input  logic [4:0]  ID_EX_rt,
  input  logic        EX_MEM_branch_taken,
  input  logic        dmem_busy,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        pipe_freeze,
  output logic [1:0]  ctl_state,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
  output logic [31:0] freeze_count
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  localparam logic [1:0] LOAD = 2'(STALL_CYCLES - 1);

  state_t     state;
  logic [1:0] cnt;
  logic       hz;
  logic       frz;
  logic       fl;
  logic       stl;

  always_comb begin
    hz  = ID_EX_mem_read && (ID_EX_rt != 5'd0) &&
          ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));
    frz = dmem_busy;
    fl  = EX_MEM_branch_taken && !frz;
    // STALL holds regardless of hz; only RUN/FLUSH look at it
    stl = !frz && !fl && ((state == STALL) || hz);
  end

  assign pc_write     = rst ? 1'b1 : (!frz && !stl);
  assign if_id_write  = rst ? 1'b1 : (!frz && !stl);
  assign if_id_flush  = rst ? 1'b0 : fl;
  assign id_ex_flush  = rst ? 1'b0 : fl;
  assign ex_mem_flush = rst ? 1'b0 : fl;
  assign id_ex_bubble = rst ? 1'b0 : stl;
  assign pipe_freeze  = rst ? 1'b0 : frz;
  assign ctl_state    = rst ? 2'b00 : state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else if (!frz) begin
      if (fl) begin
        state <= FLUSH;
        cnt   <= 2'd0;
      end else if (state == STALL) begin
        cnt <= cnt - 2'd1;
        if (cnt <= 2'd1) begin
          state <= RUN;
        end
      end else if (hz) begin
        cnt   <= LOAD;
        state <= (STALL_CYCLES > 1) ? STALL : RUN;
      end else begin
        state <= RUN;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;
  logic [31:0] freeze_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      if (id_ex_bubble) stall_q  <= stall_q + 32'd1;
      if (id_ex_flush)  flush_q  <= flush_q + 32'd1;
      if (pipe_freeze)  freeze_q <= freeze_q + 32'd1;
    end
  end

  assign stall_count  = rst ? 32'd0 : stall_q;
  assign flush_count  = rst ? 32'd0 : flush_q;
  assign freeze_count = rst ? 32'd0 : freeze_q;
`else
  assign stall_count  = 32'd0;
  assign flush_count  = 32'd0;
  assign freeze_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Bench for hazard_ctl: two instances (1- and 3-cycle stall) on one
// stimulus table, checked cycle by cycle through an expectation queue.
module tb_hazard_ctl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble,
  //  id_ex_flush, ex_mem_flush, pipe_freeze, ctl_state[1:0]}
  localparam logic [8:0] R   = 9'b110000000;
  localparam logic [8:0] RF  = 9'b110000010;
  localparam logic [8:0] SE  = 9'b000100000;
  localparam logic [8:0] SEF = 9'b000100010;
  localparam logic [8:0] SS  = 9'b000100001;
  localparam logic [8:0] FL0 = 9'b111011000;
  localparam logic [8:0] FL1 = 9'b111011001;
  localparam logic [8:0] FZ0 = 9'b000000100;
  localparam logic [8:0] FZ1 = 9'b000000101;

  typedef struct {
    logic       rst;
    logic       mr;
    logic [4:0] ert;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       bt;
    logic       busy;
    logic [8:0] e1;
    logic [8:0] e3;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       mr;
  logic [4:0] ert;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       bt;
  logic       busy;

  logic        pcw1, ifw1, iff1, bub1, idf1, exf1, frz1;
  logic        pcw3, ifw3, iff3, bub3, idf3, exf3, frz3;
  logic [1:0]  st1, st3;
  logic [31:0] sc1, fc1, zc1, sc3, fc3, zc3;
  logic [8:0]  o1, o3;

  int total = 0;
  int bad   = 0;

  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  hazard_ctl #(.STALL_CYCLES(1)) u1 (
    .clk(clk), .rst(rst),
    .IF_ID_rs(rs), .IF_ID_rt(rt),
    .ID_EX_mem_read(mr), .ID_EX_rt(ert),
    .EX_MEM_branch_taken(bt), .dmem_busy(busy),
    .pc_write(pcw1), .if_id_write(ifw1), .if_id_flush(iff1),
    .id_ex_bubble(bub1), .id_ex_flush(idf1), .ex_mem_flush(exf1),
    .pipe_freeze(frz1), .ctl_state(st1),
    .stall_count(sc1), .flush_count(fc1), .freeze_count(zc1)
  );

  hazard_ctl #(.STALL_CYCLES(3)) u3 (
    .clk(clk), .rst(rst),
    .IF_ID_rs(rs), .IF_ID_rt(rt),
    .ID_EX_mem_read(mr), .ID_EX_rt(ert),
    .EX_MEM_branch_taken(bt), .dmem_busy(busy),
    .pc_write(pcw3), .if_id_write(ifw3), .if_id_flush(iff3),
    .id_ex_bubble(bub3), .id_ex_flush(idf3), .ex_mem_flush(exf3),
    .pipe_freeze(frz3), .ctl_state(st3),
    .stall_count(sc3), .flush_count(fc3), .freeze_count(zc3)
  );

  assign o1 = {pcw1, ifw1, iff1, bub1, idf1, exf1, frz1, st1};
  assign o3 = {pcw3, ifw3, iff3, bub3, idf3, exf3, frz3, st3};

  function automatic vec_t mk(
    input logic r, input logic m, input logic [4:0] e,
    input logic [4:0] s, input logic [4:0] t,
    input logic b, input logic z,
    input logic [8:0] x1, input logic [8:0] x3
  );
    vec_t v;
    v.rst = r; v.mr = m; v.ert = e; v.rs = s; v.rt = t;
    v.bt = b; v.busy = z; v.e1 = x1; v.e3 = x3;
    return v;
  endfunction

  task automatic chk(input string nm, input int cyc,
                     input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  initial begin
    vec_t       v;
    vec_t       x;
    logic [31:0] s1b, s1f, s1z, s3b, s3f, s3z;
    s1b = 0; s1f = 0; s1z = 0; s3b = 0; s3f = 0; s3z = 0;

    // reset, with a hazard present to prove reset gating
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, R, R));
    tbl.push_back(mk(1, 1, 9, 9, 0, 0, 0, R, R));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, R));
    // hazard held three cycles on rs
    tbl.push_back(mk(0, 1, 9, 9, 0, 0, 0, SE, SE));
    tbl.push_back(mk(0, 1, 9, 9, 0, 0, 0, SE, SS));
    tbl.push_back(mk(0, 1, 9, 9, 0, 0, 0, SE, SS));
    tbl.push_back(mk(0, 0, 9, 9, 0, 0, 0, R, R));
    // one-cycle hazard on rt
    tbl.push_back(mk(0, 1, 9, 3, 9, 0, 0, SE, SE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, SS));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, SS));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, R));
    // no hazard: $zero, no mem_read, no match
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, R, R));
    tbl.push_back(mk(0, 0, 9, 9, 0, 0, 0, R, R));
    tbl.push_back(mk(0, 1, 9, 8, 10, 0, 0, R, R));
    // branch in 2nd stall cycle
    tbl.push_back(mk(0, 1, 9, 9, 0, 0, 0, SE, SE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, FL0, FL1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, RF, RF));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, R));
    // hazard seen in FLUSH state
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, FL0, FL0));
    tbl.push_back(mk(0, 1, 9, 9, 0, 0, 0, SEF, SEF));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, SS));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, SS));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, R));
    // freeze over a pending branch
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, FZ0, FZ0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, FL0, FL0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, RF, RF));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, R));
    // freeze stretches a stall
    tbl.push_back(mk(0, 1, 9, 9, 0, 0, 0, SE, SE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, FZ0, FZ1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, SS));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, SS));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, R));
    // reset in first stall cycle
    tbl.push_back(mk(0, 1, 9, 9, 0, 0, 0, SE, SE));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, R, R));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, R));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, R, R));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      rst = v.rst; mr = v.mr; ert = v.ert; rs = v.rs;
      rt = v.rt; bt = v.bt; busy = v.busy;
      sb.push_back(v);
      @(negedge clk);
      x = sb.pop_front();
      chk("ctl1", i, 32'(o1), 32'(x.e1));
      chk("ctl3", i, 32'(o3), 32'(x.e3));
      chk("stall1", i, sc1, (PERF && !x.rst) ? s1b : 32'd0);
      chk("flush1", i, fc1, (PERF && !x.rst) ? s1f : 32'd0);
      chk("freeze1", i, zc1, (PERF && !x.rst) ? s1z : 32'd0);
      chk("stall3", i, sc3, (PERF && !x.rst) ? s3b : 32'd0);
      chk("flush3", i, fc3, (PERF && !x.rst) ? s3f : 32'd0);
      chk("freeze3", i, zc3, (PERF && !x.rst) ? s3z : 32'd0);
      if (x.rst) begin
        s1b = 0; s1f = 0; s1z = 0; s3b = 0; s3f = 0; s3z = 0;
      end else begin
        s1b += 32'(x.e1[5]); s1f += 32'(x.e1[4]); s1z += 32'(x.e1[2]);
        s3b += 32'(x.e3[5]); s3f += 32'(x.e3[4]); s3z += 32'(x.e3[2]);
      end
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
